// File: rtl/aibcr3_dll_lock_pkg.sv
// Shared types and defaults for the DLL lock detector: state encoding, parameter
// defaults and the accumulator width helper.
package aibcr3_dll_lock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } dll_state_e;

    localparam int WIN_W_DEF      = 4;
    localparam int TOL_DEF        = 2;
    localparam int LOCK_CNT_DEF   = 8;
    localparam int UNLOCK_CNT_DEF = 2;
    localparam int CNT_W_DEF      = 4;

    // One extra bit for the sign and one for the +/-2^WIN_W extreme.
    function automatic int acc_width(input int win_w);
        return win_w + 2;
    endfunction

endpackage

// File: rtl/aibcr3_dll_win_acc.sv
// Window integrator: counts 2^WIN_W phase-detector samples and flags each
// window end together with whether the net up/down count stayed within TOL.
module aibcr3_dll_win_acc
    import aibcr3_dll_lock_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF,
    parameter int TOL   = TOL_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic pd_up,
    input  logic pd_dn,
    output logic win_end,
    output logic win_good
);

    localparam int AW = acc_width(WIN_W);
    localparam logic signed [AW-1:0] TOL_P = AW'(TOL);
    localparam logic signed [AW-1:0] TOL_N = -TOL_P;

    logic [WIN_W-1:0]     win_cnt;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] step;

    always_comb begin
        step = '0;
        if (pd_up && !pd_dn)
            step = AW'(1);
        else if (!pd_up && pd_dn)
            step = '1;
    end

    // The verdict includes the sample taken in the window's final cycle.
    assign acc_next = acc + step;
    assign win_end  = en && (win_cnt == '1);
    assign win_good = (acc_next <= TOL_P) && (acc_next >= TOL_N);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            win_cnt <= '0;
        end else if (clr) begin
            acc     <= '0;
            win_cnt <= '0;
        end else if (en) begin
            if (win_end) begin
                acc     <= '0;
                win_cnt <= '0;
            end else begin
                acc     <= acc_next;
                win_cnt <= win_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aibcr3_dll_lock_det.sv
// DLL lock detector: qualifies lock after LOCK_CNT good windows and drops it after
// UNLOCK_CNT bad ones. Define AIBCR3_DLL_LOCK_STICKY_EN to make lock sticky.
module aibcr3_dll_lock_det
    import aibcr3_dll_lock_pkg::*;
#(
    parameter int WIN_W      = WIN_W_DEF,
    parameter int TOL        = TOL_DEF,
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int UNLOCK_CNT = UNLOCK_CNT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk_dcd,
    input  logic             RST,
    input  logic             dll_en,
    input  logic             pd_up,
    input  logic             pd_dn,
    output logic             dll_lock,
    output logic             unlock_evt,
    output logic [CNT_W-1:0] lock_cnt_dbg
);

    dll_state_e       state, state_nxt;
    logic [CNT_W-1:0] good_cnt, good_nxt;
    logic [CNT_W-1:0] bad_cnt, bad_nxt;
    logic             lock_nxt, evt_nxt;
    logic             sample_en, win_end, win_good;
    logic             lock_hit, unlock_hit;

    assign sample_en = dll_en && (state != IDLE);

    aibcr3_dll_win_acc #(
        .WIN_W (WIN_W),
        .TOL   (TOL)
    ) u_win_acc (
        .clk      (clk_dcd),
        .rst      (RST),
        .clr      (!dll_en),
        .en       (sample_en),
        .pd_up    (pd_up),
        .pd_dn    (pd_dn),
        .win_end  (win_end),
        .win_good (win_good)
    );

    assign lock_hit = (state == ACQ) && win_end && win_good
                      && (good_cnt == CNT_W'(LOCK_CNT - 1));
`ifdef AIBCR3_DLL_LOCK_STICKY_EN
    assign unlock_hit = 1'b0;
`else
    assign unlock_hit = (state == LOCKED) && win_end && !win_good
                        && (bad_cnt == CNT_W'(UNLOCK_CNT - 1));
`endif

    always_ff @(posedge clk_dcd or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            dll_lock   <= 1'b0;
            unlock_evt <= 1'b0;
        end else begin
            state      <= state_nxt;
            good_cnt   <= good_nxt;
            bad_cnt    <= bad_nxt;
            dll_lock   <= lock_nxt;
            unlock_evt <= evt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!dll_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ACQ;
                ACQ:     if (lock_hit) state_nxt = LOCKED;
                LOCKED:  if (unlock_hit) state_nxt = ACQ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Disabling is deliberate, so it clears everything without an unlock pulse.
    always_comb begin
        good_nxt = good_cnt;
        bad_nxt  = bad_cnt;
        evt_nxt  = 1'b0;
        lock_nxt = (state_nxt == LOCKED);
        if (!dll_en) begin
            good_nxt = '0;
            bad_nxt  = '0;
        end else begin
            case (state)
                ACQ: begin
                    if (win_end)
                        good_nxt = win_good ? good_cnt + 1'b1 : '0;
                end
                LOCKED: begin
                    if (unlock_hit) begin
                        good_nxt = '0;
                        bad_nxt  = '0;
                        evt_nxt  = 1'b1;
                    end else if (win_end) begin
`ifdef AIBCR3_DLL_LOCK_STICKY_EN
                        bad_nxt = '0;
`else
                        bad_nxt = win_good ? '0 : bad_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    good_nxt = '0;
                    bad_nxt  = '0;
                end
            endcase
        end
    end

    assign lock_cnt_dbg = good_cnt;

endmodule

// File: tb/tb_aibcr3_dll_lock_det.sv
// Scoreboard bench for aibcr3_dll_lock_det: a window-sum reference model predicts
// the outputs after every edge; a monitor compares them.
module tb_aibcr3_dll_lock_det;

    localparam int WIN_W      = 4;
    localparam int W          = 1 << WIN_W;
    localparam int TOL        = 2;
    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_CNT = 2;
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic             lock;
        logic             evt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk_dcd = 1'b0;
    logic             RST = 1'b1;
    logic             dll_en = 1'b0;
    logic             pd_up = 1'b0;
    logic             pd_dn = 1'b0;
    logic             dll_lock;
    logic             unlock_evt;
    logic [CNT_W-1:0] lock_cnt_dbg;

    int tests = 0;
    int fails = 0;

    exp_t exp_q[$];

    // Reference model state, expressed in terms of window sums and streaks.
    bit m_active, m_locked;
    int m_good, m_bad;
    int m_win[$];

    aibcr3_dll_lock_det #(
        .WIN_W      (WIN_W),
        .TOL        (TOL),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_dcd      (clk_dcd),
        .RST          (RST),
        .dll_en       (dll_en),
        .pd_up        (pd_up),
        .pd_dn        (pd_dn),
        .dll_lock     (dll_lock),
        .unlock_evt   (unlock_evt),
        .lock_cnt_dbg (lock_cnt_dbg)
    );

    always #5 clk_dcd = ~clk_dcd;

    task automatic chk(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk_dcd) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({dll_lock, unlock_evt, lock_cnt_dbg} !== e) begin
                fails++;
                $display("FAIL outputs t=%0t: lock/evt/cnt actual=%b/%b/%0d expected=%b/%b/%0d",
                         $time, dll_lock, unlock_evt, lock_cnt_dbg, e.lock, e.evt, e.cnt);
            end
        end
    end

    function automatic void model_reset();
        m_active = 0;
        m_locked = 0;
        m_good   = 0;
        m_bad    = 0;
        m_win.delete();
    endfunction

    function automatic exp_t model_step(input bit en, input bit up, input bit dn);
        exp_t r;
        int   sum;
        bit   good;
        bit   evt = 0;
        if (!en) begin
            model_reset();
        end else if (!m_active) begin
            m_active = 1;
        end else begin
            m_win.push_back((up && !dn) ? 1 : ((dn && !up) ? -1 : 0));
            if (m_win.size() == W) begin
                sum = 0;
                foreach (m_win[i]) sum += m_win[i];
                m_win.delete();
                good = (sum <= TOL) && (sum >= -TOL);
                if (!m_locked) begin
                    m_good = good ? m_good + 1 : 0;
                    if (m_good == LOCK_CNT) m_locked = 1;
                end else begin
`ifndef AIBCR3_DLL_LOCK_STICKY_EN
                    m_bad = good ? 0 : m_bad + 1;
                    if (m_bad == UNLOCK_CNT) begin
                        m_locked = 0;
                        m_good   = 0;
                        m_bad    = 0;
                        evt      = 1;
                    end
`endif
                end
            end
        end
        r.lock = m_locked;
        r.evt  = evt;
        r.cnt  = CNT_W'(m_good);
        return r;
    endfunction

    task automatic step(input bit en, input bit up, input bit dn);
        @(negedge clk_dcd);
        dll_en = en;
        pd_up  = up;
        pd_dn  = dn;
        exp_q.push_back(model_step(en, up, dn));
    endtask

    // One window whose net up-minus-down equals 'net'; filler samples are both/neither.
    task automatic send_window(input int net);
        int mag = (net < 0) ? -net : net;
        for (int i = 0; i < W; i++) begin
            if (i < mag)
                step(1'b1, net > 0, net < 0);
            else if ($urandom_range(0, 1) == 1)
                step(1'b1, 1'b1, 1'b1);
            else
                step(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic good_windows(input int n);
        for (int k = 0; k < n; k++) send_window(int'($urandom_range(0, 4)) - 2);
    endtask

    task automatic async_reset();
        @(negedge clk_dcd);
        #2 RST = 1'b1;
        #1;
        chk("rst_async_lock", dll_lock, 0);
        chk("rst_async_evt", unlock_evt, 0);
        chk("rst_async_cnt", lock_cnt_dbg, 0);
        @(negedge clk_dcd);
        RST    = 1'b0;
        dll_en = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        #3;
        chk("reset_lock", dll_lock, 0);
        chk("reset_evt", unlock_evt, 0);
        chk("reset_cnt", lock_cnt_dbg, 0);
        @(negedge clk_dcd);
        RST = 1'b0;

        // Alternating decisions: lock exactly 1 + LOCK_CNT*W cycles after enable.
        step(0, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < LOCK_CNT * W - 1; i++) step(1, i[0], !i[0]);
        @(posedge clk_dcd) #2;
        chk("lock_latency_early", dll_lock, 0);
        step(1, 1, 0);
        @(posedge clk_dcd) #2;
        chk("lock_latency_129", dll_lock, 1);
        chk("lock_cnt_at_lock", lock_cnt_dbg, LOCK_CNT);

        // Constant late: two bad windows drop lock with a single pulse.
        for (int i = 0; i < 2 * W; i++) step(1, 1, 0);
        step(1, 0, 0);
        @(posedge clk_dcd) #2;
`ifdef AIBCR3_DLL_LOCK_STICKY_EN
        chk("sticky_keeps_lock", dll_lock, 1);
`else
        chk("unlock_drops_lock", dll_lock, 0);
`endif
        for (int i = 0; i < W - 1; i++) step(1, 0, 0);

        // Seven good, one bad, then a fresh streak of eight.
        async_reset();
        step(1, 0, 0);
        good_windows(LOCK_CNT - 1);
        send_window(3);
        good_windows(LOCK_CNT);

        // Tolerance boundary while locked.
        send_window(2);
        send_window(-2);
        send_window(3);
        send_window(TOL);
        send_window(-3);
        send_window(-3);
        good_windows(LOCK_CNT + 1);

        // Short disable mid-window, then relock from an empty window.
        for (int i = 0; i < 5; i++) step(1, 1, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        good_windows(LOCK_CNT);
        for (int i = 0; i < 7; i++) step(1, $urandom_range(0, 1), $urandom_range(0, 1));

        // Reset while locked, mid-window.
        async_reset();
        step(1, 0, 0);
        good_windows(LOCK_CNT);
        for (int i = 0; i < 2 * W; i++) step(1, 1, 0);

        // Random windows with occasional disables.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < int'($urandom_range(0, 20)); i++)
                    step(1, $urandom_range(0, 1), $urandom_range(0, 1));
                step(0, 0, 0);
                step(1, 0, 0);
            end
            send_window(int'($urandom_range(0, 8)) - 4);
        end

        step(1, 0, 0);
        @(posedge clk_dcd) #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
